// File: rtl/boa_stage_mem.sv
// MEM pipeline stage: EX/MEM barrier, load/store bus access, load result formatting.
// A completed access whose barrier is held by fw_stall_mem parks in StDone with the
// read data latched, so the bus access is never repeated while the pipeline is frozen.
module boa_stage_mem #(
  parameter bit misalign_trap = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  // EX/MEM inputs
  input  logic        d_valid,
  input  logic [31:1] d_pc,
  input  logic [31:0] d_insn,
  input  logic        d_use_rd,
  input  logic [31:0] d_rs1_val,
  input  logic [31:0] d_rs2_val,
  input  logic        d_trap,
  input  logic [3:0]  d_cause,
  // MEM/WB outputs
  output logic        q_valid,
  output logic [31:1] q_pc,
  output logic [31:0] q_insn,
  output logic        q_use_rd,
  output logic [31:0] q_rd_val,
  output logic        q_trap,
  output logic [3:0]  q_cause,
  // data bus
  output logic        bus_re,
  output logic [3:0]  bus_we,
  output logic [31:2] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ready,
  // hazard interface
  input  logic        fw_stall_mem,
  output logic        fw_rd,
  output logic        stall_req
);

  localparam logic [4:0] op_load  = 5'b00000;
  localparam logic [4:0] op_store = 5'b01000;

  typedef enum logic {StIdle, StDone} state_e;

  state_e state, state_next;

  logic        r_valid;
  logic [31:1] r_pc;
  logic [31:0] r_insn;
  logic        r_use_rd;
  logic [31:0] r_rs1_val;
  logic [31:0] r_rs2_val;
  logic        r_trap;
  logic [3:0]  r_cause;
  logic [31:0] rdata_hold;

  logic        is_load, is_store, mem_op, is_unsigned;
  logic [1:0]  size, addr_lo, eff_lo;
  logic        misaligned, mis_block, mis_trap;
  logic        eligible, transfer;
  logic [3:0]  lane_mask;
  logic [31:0] rdata_src, shifted, load_val;

  // EX/MEM barrier: advances unless the hazard unit holds it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_trap  <= 1'b0;
    end else if (!fw_stall_mem) begin
      r_valid   <= d_valid;
      r_pc      <= d_pc;
      r_insn    <= d_insn;
      r_use_rd  <= d_use_rd;
      r_rs1_val <= d_rs1_val;
      r_rs2_val <= d_rs2_val;
      r_trap    <= d_trap;
      r_cause   <= d_cause;
    end
  end

  // Decode, alignment check and bus request generation
  always_comb begin
    is_load     = (r_insn[6:2] == op_load);
    is_store    = (r_insn[6:2] == op_store);
    mem_op      = is_load || is_store;
    size        = r_insn[13:12];
    is_unsigned = r_insn[14];
    addr_lo     = r_rs1_val[1:0];
    misaligned  = ((size == 2'b01) && addr_lo[0]) || ((size == 2'b10) && (addr_lo != 2'b00));
    mis_block   = misalign_trap && misaligned;
    mis_trap    = r_valid && mem_op && mis_block;
    // Without trapping, a misaligned access is issued as if it were aligned
    eff_lo      = (!misalign_trap && misaligned) ? 2'b00 : addr_lo;

    eligible  = r_valid && mem_op && !r_trap && !mis_block && !clear && (state == StIdle);
    transfer  = eligible && bus_ready;
    stall_req = eligible && !bus_ready;

    case (size)
      2'b00:   lane_mask = 4'b0001 << eff_lo;
      2'b01:   lane_mask = eff_lo[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase

    case (size)
      2'b00:   bus_wdata = {4{r_rs2_val[7:0]}};
      2'b01:   bus_wdata = {2{r_rs2_val[15:0]}};
      default: bus_wdata = r_rs2_val;
    endcase

    bus_re   = eligible && is_load;
    bus_we   = (eligible && is_store) ? lane_mask : 4'b0000;
    bus_addr = r_rs1_val[31:2];
  end

  // Load result alignment and extension; StDone replays the latched data
  always_comb begin
    rdata_src = (state == StDone) ? rdata_hold : bus_rdata;
    shifted   = rdata_src >> {eff_lo, 3'b000};
    case (size)
      2'b00:   load_val = {{24{!is_unsigned && shifted[7]}}, shifted[7:0]};
      2'b01:   load_val = {{16{!is_unsigned && shifted[15]}}, shifted[15:0]};
      default: load_val = shifted;
    endcase
    q_rd_val = is_load ? load_val : r_rs1_val;
  end

  // MEM/WB outputs and forwarding qualifier
  always_comb begin
    q_valid  = r_valid && !clear && !stall_req;
    q_trap   = !clear && (r_trap || mis_trap);
    q_cause  = r_trap ? r_cause : (is_load ? 4'd4 : 4'd6);
    q_pc     = r_pc;
    q_insn   = r_insn;
    q_use_rd = r_use_rd;
    fw_rd    = r_valid && r_use_rd && !r_trap && (!is_load || transfer || (state == StDone));
  end

  // Access FSM next state
  always_comb begin
    state_next = state;
    case (state)
      StIdle:  if (transfer && fw_stall_mem) state_next = StDone;
      StDone:  if (!fw_stall_mem) state_next = StIdle;
      default: state_next = StIdle;
    endcase
  end

  // Access FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= StIdle;
    else     state <= state_next;
  end

  // Capture read data when a completed access must wait in StDone
  always_ff @(posedge clk) begin
    if ((state == StIdle) && transfer && fw_stall_mem) rdata_hold <= bus_rdata;
  end

endmodule

// File: tb/tb_boa_stage_mem.sv
// Directed bench for boa_stage_mem with hand-computed expected values.
module tb_boa_stage_mem;

  logic        clk, rst, clear;
  logic        d_valid, d_use_rd, d_trap;
  logic [31:1] d_pc;
  logic [31:0] d_insn, d_rs1_val, d_rs2_val;
  logic [3:0]  d_cause;
  logic        q_valid, q_use_rd, q_trap;
  logic [31:1] q_pc;
  logic [31:0] q_insn, q_rd_val;
  logic [3:0]  q_cause;
  logic        bus_re, bus_ready;
  logic [3:0]  bus_we;
  logic [31:2] bus_addr;
  logic [31:0] bus_wdata, bus_rdata;
  logic        fw_stall_mem, fw_rd, stall_req;

  int n_checks = 0;
  int n_pass   = 0;
  int re_pulses;

  localparam logic [6:0] OpLoad  = 7'h03;
  localparam logic [6:0] OpStore = 7'h23;
  localparam logic [6:0] OpAlu   = 7'h13;

  boa_stage_mem #(.misalign_trap(1'b1)) dut (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .d_valid      (d_valid),
    .d_pc         (d_pc),
    .d_insn       (d_insn),
    .d_use_rd     (d_use_rd),
    .d_rs1_val    (d_rs1_val),
    .d_rs2_val    (d_rs2_val),
    .d_trap       (d_trap),
    .d_cause      (d_cause),
    .q_valid      (q_valid),
    .q_pc         (q_pc),
    .q_insn       (q_insn),
    .q_use_rd     (q_use_rd),
    .q_rd_val     (q_rd_val),
    .q_trap       (q_trap),
    .q_cause      (q_cause),
    .bus_re       (bus_re),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_rdata    (bus_rdata),
    .bus_ready    (bus_ready),
    .fw_stall_mem (fw_stall_mem),
    .fw_rd        (fw_rd),
    .stall_req    (stall_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before 200000");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [31:0] mk_insn(input logic [2:0] f3, input logic [6:0] op);
    return {17'd0, f3, 5'd5, op};
  endfunction

  // Load one instruction into the barrier; returns #1 after the capturing edge
  task automatic issue(input logic [31:0] insn, input logic use_rd, input logic [31:0] rs1,
                       input logic [31:0] rs2, input logic trap, input logic [3:0] cause);
    d_valid = 1'b1; d_insn = insn; d_use_rd = use_rd; d_rs1_val = rs1; d_rs2_val = rs2;
    d_trap = trap; d_cause = cause; d_pc = 31'h0000_0200;
    fw_stall_mem = 1'b0; bus_ready = 1'b0; clear = 1'b0;
    @(posedge clk); #1;
    d_valid = 1'b0; d_trap = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; fw_stall_mem = 1'b0; bus_ready = 1'b0; bus_rdata = '0;
    d_valid = 1'b1; d_trap = 1'b1; d_cause = 4'd2; d_pc = '0; d_use_rd = 1'b1;
    d_insn = mk_insn(3'b010, OpLoad); d_rs1_val = 32'h100; d_rs2_val = '0;

    // Reset wins over a valid, trapping input
    @(posedge clk); #1;
    check("rst_q_valid", {31'd0, q_valid}, 32'd0);
    check("rst_q_trap", {31'd0, q_trap}, 32'd0);
    check("rst_bus_re", {31'd0, bus_re}, 32'd0);
    check("rst_bus_we", {28'd0, bus_we}, 32'd0);
    check("rst_stall", {31'd0, stall_req}, 32'd0);
    check("rst_fw_rd", {31'd0, fw_rd}, 32'd0);
    rst = 1'b0; d_valid = 1'b0; d_trap = 1'b0;
    @(posedge clk); #1;

    // LB 0x1003, ready same cycle
    issue(mk_insn(3'b000, OpLoad), 1'b1, 32'h1003, 32'h0, 1'b0, 4'd0);
    bus_rdata = 32'h80FF_FFFF; bus_ready = 1'b1; #1;
    check("lb_re", {31'd0, bus_re}, 32'd1);
    check("lb_addr", {2'b00, bus_addr}, 32'h400);
    check("lb_val", q_rd_val, 32'hFFFF_FF80);
    check("lb_stall", {31'd0, stall_req}, 32'd0);
    check("lb_q_valid", {31'd0, q_valid}, 32'd1);
    check("lb_fw_rd", {31'd0, fw_rd}, 32'd1);

    // LBU same address
    issue(mk_insn(3'b100, OpLoad), 1'b1, 32'h1003, 32'h0, 1'b0, 4'd0);
    bus_rdata = 32'h80FF_FFFF; bus_ready = 1'b1; #1;
    check("lbu_val", q_rd_val, 32'h0000_0080);

    // SH 0x2002
    issue(mk_insn(3'b001, OpStore), 1'b0, 32'h2002, 32'h0000_ABCD, 1'b0, 4'd0);
    bus_ready = 1'b1; #1;
    check("sh_we", {28'd0, bus_we}, 32'hC);
    check("sh_wdata", bus_wdata, 32'hABCD_ABCD);
    check("sh_re", {31'd0, bus_re}, 32'd0);

    // LHU 0x2002
    issue(mk_insn(3'b101, OpLoad), 1'b1, 32'h2002, 32'h0, 1'b0, 4'd0);
    bus_rdata = 32'hABCD_1234; bus_ready = 1'b1; #1;
    check("lhu_val", q_rd_val, 32'h0000_ABCD);

    // LH 0x2000, negative half
    issue(mk_insn(3'b001, OpLoad), 1'b1, 32'h2000, 32'h0, 1'b0, 4'd0);
    bus_rdata = 32'h0000_8001; bus_ready = 1'b1; #1;
    check("lh_val", q_rd_val, 32'hFFFF_8001);

    // SB 0x2001
    issue(mk_insn(3'b000, OpStore), 1'b0, 32'h2001, 32'h1234_5678, 1'b0, 4'd0);
    bus_ready = 1'b1; #1;
    check("sb_we", {28'd0, bus_we}, 32'h2);
    check("sb_wdata", bus_wdata, 32'h7878_7878);

    // LW 0x3000 with 3 wait cycles
    issue(mk_insn(3'b010, OpLoad), 1'b1, 32'h3000, 32'h0, 1'b0, 4'd0);
    fw_stall_mem = 1'b1; bus_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("lw_wait%0d_stall", i), {31'd0, stall_req}, 32'd1);
      check($sformatf("lw_wait%0d_qv", i), {31'd0, q_valid}, 32'd0);
      @(posedge clk); #1;
    end
    fw_stall_mem = 1'b0; bus_ready = 1'b1; bus_rdata = 32'hDEAD_BEEF; #1;
    check("lw_done_qv", {31'd0, q_valid}, 32'd1);
    check("lw_done_fw", {31'd0, fw_rd}, 32'd1);
    check("lw_done_val", q_rd_val, 32'hDEAD_BEEF);
    check("lw_done_stall", {31'd0, stall_req}, 32'd0);

    // Misaligned LW / SW
    issue(mk_insn(3'b010, OpLoad), 1'b1, 32'h3002, 32'h0, 1'b0, 4'd0);
    bus_ready = 1'b1; #1;
    check("mis_lw_re", {31'd0, bus_re}, 32'd0);
    check("mis_lw_trap", {31'd0, q_trap}, 32'd1);
    check("mis_lw_cause", {28'd0, q_cause}, 32'd4);
    issue(mk_insn(3'b010, OpStore), 1'b0, 32'h3001, 32'h0, 1'b0, 4'd0);
    bus_ready = 1'b1; #1;
    check("mis_sw_cause", {28'd0, q_cause}, 32'd6);
    check("mis_sw_we", {28'd0, bus_we}, 32'd0);

    // Incoming trap passes its own cause and blocks the access
    issue(mk_insn(3'b010, OpLoad), 1'b1, 32'h3000, 32'h0, 1'b1, 4'd2);
    bus_ready = 1'b1; #1;
    check("in_trap_re", {31'd0, bus_re}, 32'd0);
    check("in_trap_cause", {28'd0, q_cause}, 32'd2);
    check("in_trap_fw", {31'd0, fw_rd}, 32'd0);

    // LW completes while the barrier is held: one access, data replayed from StDone
    issue(mk_insn(3'b010, OpLoad), 1'b1, 32'h3004, 32'h0, 1'b0, 4'd0);
    bus_rdata = 32'h1122_3344; bus_ready = 1'b1; fw_stall_mem = 1'b1; #1;
    re_pulses = int'(bus_re);
    check("hold_a_val", q_rd_val, 32'h1122_3344);
    @(posedge clk); #1;
    bus_rdata = 32'h5555_5555; #1;
    re_pulses += int'(bus_re);
    check("hold_b_val", q_rd_val, 32'h1122_3344);
    check("hold_b_qv", {31'd0, q_valid}, 32'd1);
    check("hold_b_fw", {31'd0, fw_rd}, 32'd1);
    @(posedge clk); #1;
    fw_stall_mem = 1'b0; #1;
    re_pulses += int'(bus_re);
    check("hold_c_val", q_rd_val, 32'h1122_3344);
    check("hold_re_pulses", re_pulses, 32'd1);
    @(posedge clk); #1;
    check("hold_after_re", {31'd0, bus_re}, 32'd0);

    // SW pending, then clear
    issue(mk_insn(3'b010, OpStore), 1'b0, 32'h4000, 32'hCAFE_0001, 1'b0, 4'd0);
    fw_stall_mem = 1'b1; bus_ready = 1'b0; #1;
    check("sw_pend_we", {28'd0, bus_we}, 32'hF);
    clear = 1'b1; #1;
    check("sw_clear_we", {28'd0, bus_we}, 32'd0);
    check("sw_clear_qv", {31'd0, q_valid}, 32'd0);
    check("sw_clear_stall", {31'd0, stall_req}, 32'd0);
    clear = 1'b0;

    // rst mid-LW
    issue(mk_insn(3'b010, OpLoad), 1'b1, 32'h5000, 32'h0, 1'b0, 4'd0);
    fw_stall_mem = 1'b1; bus_ready = 1'b0; #1;
    check("rst_lw_pend_re", {31'd0, bus_re}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_lw_re", {31'd0, bus_re}, 32'd0);
    check("rst_lw_qv", {31'd0, q_valid}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_lw_after_re", {31'd0, bus_re}, 32'd0);
    check("rst_lw_after_stall", {31'd0, stall_req}, 32'd0);

    // Non-memory instruction passes rs1 through
    issue(mk_insn(3'b000, OpAlu), 1'b1, 32'hCAFE_F00D, 32'h0, 1'b0, 4'd0);
    #1;
    check("alu_val", q_rd_val, 32'hCAFE_F00D);
    check("alu_fw", {31'd0, fw_rd}, 32'd1);
    check("alu_re", {31'd0, bus_re}, 32'd0);
    check("alu_pc", {1'b0, q_pc}, 32'h200);
    check("alu_insn", q_insn, 32'h0000_0293);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
